score_digit_ctrl: RTL and testbench

SCORE_DIGIT_CTRL -- requirements
Module: score_digit_ctrl

---
 rtl/score_pkg.sv | 31 +++
 rtl/score_digit_ctrl_dabble_step.sv | 21 ++
 rtl/score_digit_ctrl.sv | 118 +++++++++++
 tb/tb_score_digit_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score digit controller.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam int MAX_SCORE = 999;
  localparam int BCD_ITER  = 10;
  localparam int BIN_W     = 10;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Clamp a raw count to the largest value three digits can show.
  function automatic logic [BIN_W-1:0] sat_score(input logic [BIN_W-1:0] v);
    return (v > BIN_W'(MAX_SCORE)) ? BIN_W'(MAX_SCORE) : v;
  endfunction

  // Double-dabble nibble correction.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/score_digit_ctrl_dabble_step.sv
// One combinational double-dabble iteration: add-3 correction, then shift in the next binary bit.
module dabble_step
  import score_pkg::*;
(
  input  bcd_t bcd,
  input  logic bin_msb,
  output bcd_t bcd_next
);

  bcd_t adj;

  // Correct each nibble, then shift the whole BCD word left by one.
  always_comb begin
    adj          = bcd;
    adj.hundreds = add3(bcd.hundreds);
    adj.tens     = add3(bcd.tens);
    adj.ones     = add3(bcd.ones);
    bcd_next     = {adj[10:0], bin_msb};
  end

endmodule

// File: rtl/score_digit_ctrl.sv
// Converts a binary score to three BCD digits and commits them to the renderers,
// optionally only on a frame boundary so a digit never changes mid-frame.
//
// state   | meaning
// IDLE    | no work; waiting for i_start
// CONVERT | 10 double-dabble iterations on the captured value
// HOLD    | result ready; waiting for the commit point (frame start or immediate)
// COMMIT  | new digits visible, o_done high; chain to a pending request if any
module score_digit_ctrl
  import score_pkg::*;
#(
  parameter bit FRAME_SYNC = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [9:0] i_value,
  input  logic       i_frame_start,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_hundreds,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic [2:0] o_digit_en
);

  state_t           state;
  logic [3:0]       cnt;
  logic [BIN_W-1:0] bin_sr;
  bcd_t             bcd_acc;
  bcd_t             bcd_step;
  logic             pend_valid;
  logic [BIN_W-1:0] pend_val;
  logic             hold_go;

  dabble_step u_step (
    .bcd      (bcd_acc),
    .bin_msb  (bin_sr[BIN_W-1]),
    .bcd_next (bcd_step)
  );

  assign hold_go = FRAME_SYNC ? i_frame_start : 1'b1;
  assign o_busy  = (state != IDLE) || pend_valid;

  // Sequencer: capture, iterate, wait for the commit point, publish digits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bin_sr     <= '0;
      bcd_acc    <= '0;
      pend_valid <= 1'b0;
      pend_val   <= '0;
      o_done     <= 1'b0;
      o_hundreds <= '0;
      o_tens     <= '0;
      o_ones     <= '0;
      o_digit_en <= 3'b001;
    end else begin
      o_done <= 1'b0;

      // Requests arriving mid-flight queue in a single slot; newest wins.
      if (i_start && (state == CONVERT || state == HOLD)) begin
        pend_valid <= 1'b1;
        pend_val   <= sat_score(i_value);
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            bin_sr  <= sat_score(i_value);
            bcd_acc <= '0;
            cnt     <= '0;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_acc <= bcd_step;
          bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
          if (cnt == 4'(BCD_ITER - 1)) begin
            state <= HOLD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          if (hold_go) begin
            o_hundreds <= bcd_acc.hundreds;
            o_tens     <= bcd_acc.tens;
            o_ones     <= bcd_acc.ones;
            o_digit_en <= {(bcd_acc.hundreds != 4'd0),
                           (bcd_acc.hundreds != 4'd0) || (bcd_acc.tens != 4'd0),
                           1'b1};
            o_done     <= 1'b1;
            state      <= COMMIT;
          end
        end
        COMMIT: begin
          // A start in this very cycle is newer than anything already queued.
          bcd_acc    <= '0;
          cnt        <= '0;
          pend_valid <= 1'b0;
          if (i_start) begin
            bin_sr <= sat_score(i_value);
            state  <= CONVERT;
          end else if (pend_valid) begin
            bin_sr <= pend_val;
            state  <= CONVERT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Directed bench for score_digit_ctrl: one immediate-commit instance and one frame-synced instance.
module tb_score_digit_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1, frame;
  logic [9:0] value;

  logic       busy0, done0, busy1, done1;
  logic [3:0] h0, t0, o0, h1, t1, o1;
  logic [2:0] en0, en1;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_disp0;
  logic [2:0]  exp_en0;

  always #5 clk = ~clk;

  score_digit_ctrl #(.FRAME_SYNC(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_value(value), .i_frame_start(frame),
    .o_busy(busy0), .o_done(done0), .o_hundreds(h0), .o_tens(t0), .o_ones(o0), .o_digit_en(en0)
  );

  score_digit_ctrl #(.FRAME_SYNC(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_value(value), .i_frame_start(frame),
    .o_busy(busy1), .o_done(done1), .o_hundreds(h1), .o_tens(t1), .o_ones(o1), .o_digit_en(en1)
  );

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; frame = 1'b0; value = '0;
    #2;
    checks++; if ({h0, t0, o0} !== 12'h000) begin errors++; $display("FAIL reset_digits0: got %h expected 000", {h0, t0, o0}); end
    checks++; if (en0 !== 3'b001) begin errors++; $display("FAIL reset_en0: got %b expected 001", en0); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_busy_done0: got %b%b expected 00", busy0, done0); end
    checks++; if ({h1, t1, o1} !== 12'h000) begin errors++; $display("FAIL reset_digits1: got %h expected 000", {h1, t1, o1}); end
    checks++; if (en1 !== 3'b001) begin errors++; $display("FAIL reset_en1: got %b expected 001", en1); end
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL reset_busy_done1: got %b%b expected 00", busy1, done1); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_disp0 = 12'h000;
    exp_en0   = 3'b001;
  endtask

  // Single request on the immediate instance: latency 12, stable display until commit, one-cycle done.
  task automatic test_convert(input logic [9:0] v, input logic [11:0] edig, input logic [2:0] een);
    int k;
    bit found, stable, busy_ok;
    found = 0; stable = 1; busy_ok = 1; k = 0;
    @(negedge clk);
    start0 = 1'b1; value = v;
    while (!found && k < 30) begin
      @(negedge clk);
      start0 = 1'b0;
      k++;
      if (done0) found = 1;
      else begin
        if ({h0, t0, o0} !== exp_disp0 || en0 !== exp_en0) stable = 0;
        if (busy0 !== 1'b1) busy_ok = 0;
      end
    end
    checks++; if (!found || k != 12) begin errors++; $display("FAIL latency_%0d: got %0d cycles (found=%0d) expected 12", v, k, found); end
    checks++; if (!stable) begin errors++; $display("FAIL stable_%0d: display changed before commit, expected %h", v, exp_disp0); end
    checks++; if (!busy_ok) begin errors++; $display("FAIL busy_%0d: busy dropped during conversion, expected 1", v); end
    checks++; if ({h0, t0, o0} !== edig) begin errors++; $display("FAIL digits_%0d: got %h expected %h", v, {h0, t0, o0}, edig); end
    checks++; if (en0 !== een) begin errors++; $display("FAIL digit_en_%0d: got %b expected %b", v, en0, een); end
    @(negedge clk);
    checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL after_commit_%0d: got done=%b busy=%b expected 0 0", v, done0, busy0); end
    checks++; if ({h0, t0, o0} !== edig) begin errors++; $display("FAIL hold_digits_%0d: got %h expected %h", v, {h0, t0, o0}, edig); end
    exp_disp0 = edig;
    exp_en0   = een;
  endtask

  // Queue requests while busy; optionally the last one lands in the COMMIT cycle.
  task automatic test_back_to_back(input bit in_commit);
    int k, n;
    int pk [2];
    logic [11:0] pd [2];
    logic [2:0]  pe [2];
    bit busy_gap;
    n = 0; busy_gap = 1;
    pk[0] = 0; pk[1] = 0; pd[0] = '0; pd[1] = '0; pe[0] = '0; pe[1] = '0;
    @(negedge clk);
    start0 = 1'b1; value = 10'd10;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (!in_commit && k == 3) begin start0 = 1'b1; value = 10'd20; end
      if (!in_commit && k == 5) begin start0 = 1'b1; value = 10'd30; end
      if (in_commit && k == 12) begin start0 = 1'b1; value = 10'd77; end
      if (done0) begin
        if (n < 2) begin pk[n] = k; pd[n] = {h0, t0, o0}; pe[n] = en0; end
        n++;
      end
      if (k > 12 && k < 24 && busy0 !== 1'b1) busy_gap = 0;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_pulses(%0d): got %0d expected 2", in_commit, n); end
    checks++; if (pd[0] !== 12'h010 || pe[0] !== 3'b011) begin errors++; $display("FAIL b2b_first(%0d): got %h/%b expected 010/011", in_commit, pd[0], pe[0]); end
    if (in_commit) begin
      checks++; if (pd[1] !== 12'h077 || pe[1] !== 3'b011) begin errors++; $display("FAIL commit_start_second: got %h/%b expected 077/011", pd[1], pe[1]); end
    end else begin
      checks++; if (pd[1] !== 12'h030 || pe[1] !== 3'b011) begin errors++; $display("FAIL b2b_second: got %h/%b expected 030/011", pd[1], pe[1]); end
    end
    checks++; if (pk[0] != 12 || pk[1] != 24) begin errors++; $display("FAIL b2b_timing(%0d): got %0d,%0d expected 12,24", in_commit, pk[0], pk[1]); end
    checks++; if (!busy_gap) begin errors++; $display("FAIL b2b_busy(%0d): busy low between commits, expected 1", in_commit); end
    exp_disp0 = pd[1];
    exp_en0   = pe[1];
  endtask

  // Frame-synced instance: a pulse during conversion is ignored, the one in HOLD commits.
  task automatic test_sync();
    int k;
    bit quiet;
    quiet = 1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_disp0 = 12'h000; exp_en0 = 3'b001;
    @(negedge clk);
    start1 = 1'b1; value = 10'd123;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      frame = (k == 5 || k == 40);
      if (done1 !== 1'b0 || {h1, t1, o1} !== 12'h000 || en1 !== 3'b001) quiet = 0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL sync_early: display or done changed before frame pulse in HOLD, expected 000/001"); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sync_busy_hold: got %b expected 1", busy1); end
    @(negedge clk);
    frame = 1'b0;
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL sync_done: got %b expected 1", done1); end
    checks++; if ({h1, t1, o1} !== 12'h123 || en1 !== 3'b111) begin errors++; $display("FAIL sync_digits: got %h/%b expected 123/111", {h1, t1, o1}, en1); end
    @(negedge clk);
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL sync_after: got done=%b busy=%b expected 0 0", done1, busy1); end
  endtask

  // Reset in iteration 5 of 999, then a start on the first edge after release.
  task automatic test_reset_mid();
    int k, n;
    logic [11:0] pd;
    logic [2:0]  pe;
    n = 0; pd = '0; pe = '0;
    @(negedge clk);
    start0 = 1'b1; value = 10'd999;
    for (k = 1; k <= 6; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++; if ({h0, t0, o0} !== 12'h000 || en0 !== 3'b001) begin errors++; $display("FAIL rstmid_digits: got %h/%b expected 000/001", {h0, t0, o0}, en0); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy_done: got %b%b expected 00", busy0, done0); end
    @(negedge clk);
    rst = 1'b0; start0 = 1'b1; value = 10'd5;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0) begin
        if (n == 0) begin pd = {h0, t0, o0}; pe = en0; end
        n++;
        checks++; if (k != 12) begin errors++; $display("FAIL rstmid_latency: got %0d expected 12", k); end
      end
    end
    checks++; if (n != 1) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 1", n); end
    checks++; if (pd !== 12'h005 || pe !== 3'b001) begin errors++; $display("FAIL rstmid_digits_after: got %h/%b expected 005/001", pd, pe); end
  endtask

  initial begin
    test_reset();
    test_convert(10'd0,    12'h000, 3'b001);
    test_convert(10'd407,  12'h407, 3'b111);
    test_convert(10'd58,   12'h058, 3'b011);
    test_convert(10'd1023, 12'h999, 3'b111);
    test_convert(10'd100,  12'h100, 3'b111);
    test_convert(10'd9,    12'h009, 3'b001);
    test_convert(10'd90,   12'h090, 3'b011);
    test_convert(10'd999,  12'h999, 3'b111);
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_sync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
